// File: rtl/shared_gate_arbiter.sv
// Round-robin arbiter sharing one mux-built gate unit among N_REQ requesters.
// The result is held in a single registered slot on a valid/ready response port.
module shared_gate_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [2*N_REQ-1:0] req_op,
    input  logic [N_REQ-1:0]   req_a,
    input  logic [N_REQ-1:0]   req_b,
    output logic               resp_valid,
    output logic [ID_W-1:0]    resp_id,
    output logic               resp_data,
    input  logic               resp_ready
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_resp_id;
    logic              r_resp_data;

    logic              w_free;
    logic              w_found;
    logic              w_grant;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W-1:0]   w_gidx;
    logic [1:0]        w_op;
    logic              w_a;
    logic              w_b;
    logic              w_in1;
    logic              w_in0;
    logic              w_unit;

    // Circular search from r_ptr; the first valid index found wins.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            w_idx = ID_W'((32'(r_ptr) + off) % N_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    assign w_free  = (r_state == S_EMPTY) || resp_ready;
    assign w_grant = !rst && w_free && w_found;

    // Shared unit: a 2:1 mux selected by a, data inputs chosen by opcode.
    always_comb begin
        w_op  = req_op[{w_gidx, 1'b0} +: 2];
        w_a   = req_a[w_gidx];
        w_b   = req_b[w_gidx];
        w_in1 = 1'b0;
        w_in0 = 1'b0;
        case (w_op)
            2'b00:   begin w_in1 = w_b;  w_in0 = 1'b0; end
            2'b01:   begin w_in1 = 1'b1; w_in0 = w_b;  end
            2'b10:   begin w_in1 = ~w_b; w_in0 = w_b;  end
            default: begin w_in1 = ~w_b; w_in0 = 1'b1; end
        endcase
        w_unit = w_a ? w_in1 : w_in0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_grant) w_state_nxt = S_FULL;
            S_FULL:  if (resp_ready && !w_grant) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        resp_valid = (r_state == S_FULL);
        req_ready  = '0;
        if (w_grant) begin
            req_ready[w_gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_resp_id   <= '0;
            r_resp_data <= 1'b0;
        end else if (w_grant) begin
            r_ptr       <= (w_gidx == ID_W'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
            r_resp_id   <= w_gidx;
            r_resp_data <= w_unit;
        end
    end

    assign resp_id   = r_resp_id;
    assign resp_data = r_resp_data;

endmodule

// File: tb/tb_shared_gate_arbiter.sv
// Bench for shared_gate_arbiter: behavioural model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_shared_gate_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [N-1:0]   req_a;
    logic [N-1:0]   req_b;
    logic           resp_valid;
    logic [IW-1:0]  resp_id;
    logic           resp_data;
    logic           resp_ready;

    int vectors     = 0;
    int miscompares = 0;

    shared_gate_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    // Model state: slot contents, round-robin pointer, grants seen while waiting.
    bit           m_valid = 1'b0;
    int           m_id    = 0;
    bit           m_data  = 1'b0;
    int           m_ptr   = 0;
    int           m_wait [N];
    logic [N-1:0] m_last_gnt = '0;

    function automatic bit gate(input logic [1:0] op, input logic a, input logic b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return !(a & b);
        endcase
    endfunction

    function automatic int exp_grant();
        if (rst !== 1'b0) return -1;
        if (m_valid && resp_ready !== 1'b1) return -1;
        for (int off = 0; off < N; off++) begin
            if (req_valid[(m_ptr + off) % N] === 1'b1) return (m_ptr + off) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        g = exp_grant();
        m_last_gnt = '0;
        if (rst === 1'b1) begin
            m_valid = 1'b0;
            m_id    = 0;
            m_data  = 1'b0;
            m_ptr   = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else begin
            if (m_valid && resp_ready === 1'b1) m_valid = 1'b0;
            if (g >= 0) begin
                m_valid       = 1'b1;
                m_id          = g;
                m_data        = gate(req_op[2*g +: 2], req_a[g], req_b[g]);
                m_ptr         = (g + 1) % N;
                m_last_gnt[g] = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (i == g) m_wait[i] = 0;
                    else if (req_valid[i] === 1'b1) m_wait[i] = m_wait[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] eg;
        int worst;
        g  = exp_grant();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        vectors++;
        if (req_ready !== eg || resp_valid !== m_valid ||
            resp_id !== m_id[IW-1:0] || resp_data !== m_data) begin
            miscompares++;
            $display("FAIL model t=%0t: req_ready=%b want %b resp_valid=%b want %b resp_id=%0d want %0d resp_data=%b want %b",
                     $time, req_ready, eg, resp_valid, m_valid, resp_id, m_id, resp_data, m_data);
        end
        worst = 0;
        for (int i = 0; i < N; i++) if (m_wait[i] > worst) worst = m_wait[i];
        vectors++;
        if (worst > N - 1) begin
            miscompares++;
            $display("FAIL fairness t=%0t: waited %0d grants, limit %0d", $time, worst, N - 1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] tt;
        int order [6];
        logic [3:0] c;
        tt    = 16'b0111_0110_1110_1000;
        order = '{0, 1, 2, 3, 0, 1};

        rst        = 1'b1;
        req_valid  = '1;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        // Reset with everything requesting
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_id", 32'(resp_id), 32'h0);
        chk("rst_resp_data", 32'(resp_data), 32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant", 32'(req_ready), 32'h1);
        next_cycle();

        // All 16 op/a/b combinations through requester 1
        for (int k = 0; k < 16; k++) begin
            c         = 4'(k);
            req_valid = 4'b0010;
            req_op    = {4'b0, c[3:2], 2'b00};
            req_a     = {2'b0, c[1], 1'b0};
            req_b     = {2'b0, c[0], 1'b0};
            @(negedge clk);
            chk("op_grant", 32'(req_ready), 32'h2);
            next_cycle();
            req_valid = '0;
            @(negedge clk);
            chk("op_resp_id", 32'(resp_id), 32'h1);
            chk($sformatf("op_data_%0d", k), 32'(resp_data), 32'(tt[k]));
            next_cycle();
        end

        // Round robin with all valid
        req_op = '0; req_a = '0; req_b = '0;
        do_reset();
        req_valid = '1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk($sformatf("rr_%0d", j), 32'(req_ready), 32'(1) << order[j]);
            next_cycle();
        end
        req_valid = '0;
        do_reset();
        req_valid = 4'b0001;
        next_cycle();
        req_valid = 4'b1100;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("rr23_%0d", j), 32'(req_ready), (j == 1) ? 32'h8 : 32'h4);
            next_cycle();
        end

        // Backpressure on a held result, then back-to-back replace
        req_valid = 4'b1000;
        req_op    = 8'b00_00_00_00;
        req_a     = 4'b1000;
        req_b     = 4'b1000;
        @(negedge clk);
        chk("bp_grant3", 32'(req_ready), 32'h8);
        next_cycle();
        req_valid  = 4'b0001;
        resp_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'h1);
            chk("bp_id", 32'(resp_id), 32'h3);
            chk("bp_data", 32'(resp_data), 32'h1);
            chk("bp_ready", 32'(req_ready), 32'h0);
            next_cycle();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid  = '0;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 32'(resp_valid), 32'h1);
        chk("b2b_id", 32'(resp_id), 32'h0);
        chk("b2b_data", 32'(resp_data), 32'h0);

        // Reset while full and stalled
        next_cycle();
        rst = 1'b1;
        req_valid = '1;
        next_cycle();
        @(negedge clk);
        chk("mid_rst_valid", 32'(resp_valid), 32'h0);
        chk("mid_rst_id", 32'(resp_id), 32'h0);
        chk("mid_rst_data", 32'(resp_data), 32'h0);
        next_cycle();
        rst = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_ptr0", 32'(req_ready), 32'h1);
        next_cycle();

        // Randomized soak: requests held until granted
        req_valid = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (m_last_gnt[i] || !req_valid[i]) begin
                    req_valid[i]     = ($urandom_range(0, 2) != 0);
                    req_op[2*i +: 2] = 2'($urandom_range(0, 3));
                    req_a[i]         = 1'($urandom_range(0, 1));
                    req_b[i]         = 1'($urandom_range(0, 1));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            next_cycle();
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shared_gate_arbiter.md
# shared_gate_arbiter

Round-robin arbiter and sequencer that shares a single mux-built logic unit among `N_REQ` requesters. Each requester submits a 1-bit operand pair and a 2-bit opcode over a valid/ready handshake. The block grants one requester per cycle, evaluates the op in the shared unit, and holds a registered, tagged result on a valid/ready response port. It sits between the combinational mux-gate exercises and any client that needs gate evaluation without replicating the unit.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester id.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req_valid`, input, `N_REQ`: bit i means requester i has a request pending.
- `req_ready`, output, `N_REQ`: one-hot or zero; bit i means requester i is accepted this cycle.
- `req_op`, input, `2*N_REQ`: opcode for requester i in bits `[2i+1:2i]`. Encoding: 00 AND, 01 OR, 10 XOR, 11 NAND.
- `req_a`, input, `N_REQ`: operand a, one bit per requester.
- `req_b`, input, `N_REQ`: operand b, one bit per requester.
- `resp_valid`, output, 1: result held on the response port.
- `resp_id`, output, `ID_W`: index of the requester that owns the result.
- `resp_data`, output, 1: the result bit.
- `resp_ready`, input, 1: consumer accepts the result.

## Operation
- **Shared unit.** The unit is a single 2:1 mux with `a` as the select:
  - AND = a ? b : 0
  - OR = a ? 1 : b
  - XOR = a ? ~b : b
  - NAND = a ? ~b : 1
- **Slot state.** The response slot has two states:
  - EMPTY: `resp_valid`=0.
  - FULL: `resp_valid`=1.
- **Slot free.** `free` = EMPTY, or (FULL and `resp_ready`).
- **Grant.** Combinational. When `free` and `|req_valid`, grant the lowest index at or after `ptr`, searching circularly, with `req_valid` set. `req_ready` is the one-hot grant; otherwise all zero.
- **Pointer.** `ptr` is `ID_W` bits. On a grant to k: `ptr <= (k+1) mod N_REQ`. With no grant, `ptr` holds.
- **Transitions.**
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on `resp_ready` with no grant.
  - FULL→FULL on `resp_ready` with a grant (back-to-back: the result is replaced in the same edge).
  - FULL and not `resp_ready`: hold; `resp_id` and `resp_data` are stable and `req_ready` is 0.
- **Capture.** On a grant to k, register `resp_id`=k and `resp_data`=unit(`req_op`[k], `req_a`[k], `req_b`[k]).
- **Requester rule.** A requester keeps `req_valid`, op and operands stable until its `req_ready` is seen. The block does not check this.
- **Fairness.** A continuously valid requester is granted within `N_REQ` grants.
- **Reset.** `rst` has priority over everything:
  - `resp_valid`=0, `resp_id`=0, `resp_data`=0, `ptr`=0, state EMPTY.
  - `req_ready` is forced to 0 while `rst`=1.
  - Reset mid-transaction drops the held result without a handshake.

## Timing
- Latency: a request accepted at edge t shows `resp_valid`=1 with its result after edge t.
- Throughput: 1 result/cycle while `resp_ready`=1 and requests are pending.
- `req_ready` depends combinationally on `req_valid`, `resp_valid`, `resp_ready` and `ptr`. There is no combinational path from `req_a`/`req_b`/`req_op` to any output.
- First cycle after `rst` is released: a grant is possible, searching from index 0.
- `resp_ready` has no effect while `resp_valid`=0.

## Test plan
- **Reset:** `rst`=1 with all `req_valid`=1 → `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0. Drop `rst` → requester 0 is granted in the first cycle.
- **Exhaustive ops:** requester 1 alone, all 16 combinations of op × a × b, `resp_ready`=1 → each `resp_data` matches the op's truth table, with `resp_id`=1 one cycle after the grant.
- **Round-robin:** `N_REQ`=4, all valid continuously, `resp_ready`=1 → grant order 0,1,2,3,0,1. Then only 2 and 3 valid with `ptr`=1 → order 2,3,2.
- **Backpressure:** grant to requester 3 with op AND, a=1, b=1, then `resp_ready`=0 for 5 cycles → `resp_valid`=1, `resp_id`=3, `resp_data`=1 stable, `req_ready`=0 throughout. Raise `resp_ready` with requester 0 valid → requester 0 is granted in that same cycle and the slot stays FULL with `resp_id`=0.
- **Reset mid-operation:** assert `rst` while FULL and `resp_ready`=0 → next cycle `resp_valid`=0, `resp_id`=0, `resp_data`=0, `ptr`=0.
- **Fairness soak:** 1000 random cycles with random `req_valid` (held until granted) and random `resp_ready` → every result matches a scoreboard, no requester waits more than `N_REQ` grants, and `req_ready` is never multi-hot.
